// File: rtl/multi_hitcounter.sv
// multi_hitcounter: per-channel threshold hit counters for an acquisition
// window. Each channel compares its sample against its own threshold and
// counts either every cycle above threshold (level mode) or each rising
// crossing (edge mode). Counters saturate and raise a sticky overflow flag.
//
// Optional feature: define MULTI_HITCOUNTER_PEAK_EN to add the `peak` output.
// It holds the per-channel maximum sample seen while running.
module multi_hitcounter #(
  parameter int NCH    = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  running,
  input  logic                  mode,
  input  logic [NCH*DATA_W-1:0] data,
  input  logic [NCH*DATA_W-1:0] thresh,
  output logic [NCH-1:0]        we,
  output logic                  any_we,
  output logic [NCH*CNT_W-1:0]  nhit,
  output logic [NCH-1:0]        ovf
`ifdef MULTI_HITCOUNTER_PEAK_EN
  ,
  output logic [NCH*DATA_W-1:0] peak
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   above;
  logic [NCH-1:0]   prev_q, prev_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0] nhit_q [NCH];
  logic [CNT_W-1:0] nhit_d [NCH];
  logic             clear;

  // A start request only clears the run while the window is closed.
  assign clear = ss & ~running;

  // Threshold compare and write-enable generation (zero latency from data).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a bit unassigned and a latch is inferred.
    above = '0;
    we    = '0;
    for (int k = 0; k < NCH; k++) begin
      above[k] = data[k*DATA_W +: DATA_W] > thresh[k*DATA_W +: DATA_W];
      // Edge mode suppresses the enable while the channel was already above.
      we[k]    = running & above[k] & (~mode | ~prev_q[k]);
    end
  end

  assign any_we = |we;

  // Next-state for counters, sticky overflow flags and previous-above history.
  always_comb begin
    prev_d = clear ? '0 : above;
    ovf_d  = ovf_q;
    for (int k = 0; k < NCH; k++) begin
      nhit_d[k] = nhit_q[k];
      if (clear) begin
        nhit_d[k] = '0;
        ovf_d[k]  = 1'b0;
      end else if (we[k]) begin
        // Saturate rather than wrap; a hit at full scale marks the overflow.
        if (nhit_q[k] == CNT_MAX) begin
          ovf_d[k] = 1'b1;
        end else begin
          nhit_d[k] = nhit_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over clear/count.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot change results.
    if (rst) begin
      prev_q <= '0;
      ovf_q  <= '0;
      // NOTE: the counters are a small register array, not a RAM, so each
      // element is reset explicitly in a loop.
      for (int k = 0; k < NCH; k++) begin
        nhit_q[k] <= '0;
      end
    end else begin
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < NCH; k++) begin
        nhit_q[k] <= nhit_d[k];
      end
    end
  end

  // Pack the counter array onto the flat output bus.
  always_comb begin
    nhit = '0;
    for (int k = 0; k < NCH; k++) begin
      nhit[k*CNT_W +: CNT_W] = nhit_q[k];
    end
  end

  assign ovf = ovf_q;

`ifdef MULTI_HITCOUNTER_PEAK_EN
  logic [DATA_W-1:0] peak_q [NCH];
  logic [DATA_W-1:0] peak_d [NCH];

  // Peak tracking: follow any larger sample seen while the window is open.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      peak_d[k] = peak_q[k];
      if (clear) begin
        peak_d[k] = '0;
      end else if (running && (data[k*DATA_W +: DATA_W] > peak_q[k])) begin
        peak_d[k] = data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Peak registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (rst) begin
        peak_q[k] <= '0;
      end else begin
        peak_q[k] <= peak_d[k];
      end
    end
  end

  // Pack the peak array onto the flat output bus.
  always_comb begin
    peak = '0;
    for (int k = 0; k < NCH; k++) begin
      peak[k*DATA_W +: DATA_W] = peak_q[k];
    end
  end
`endif

endmodule

// File: doc/multi_hitcounter.md
MULTI_HITCOUNTER -- requirements
Module: multi_hitcounter

Interface
REQ-001 Parameter NCH, default 4: number of parallel data channels (1..16).
REQ-002 Parameter DATA_W, default 16: width of each channel sample and threshold.
REQ-003 Parameter CNT_W, default 9: width of each per-channel hit counter.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ss  input  1  synchronous start; clears the run when running=0.
REQ-007 running  input  1  acquisition window, from the address generator.
REQ-008 mode  input  1  0 = level counting, 1 = edge counting.
REQ-009 data  input  NCH*DATA_W  channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 thresh  input  NCH*DATA_W  per-channel thresholds, packed like data.
REQ-011 we  output  NCH  per-channel write enable, combinational.
REQ-012 any_we  output  1  OR of all we bits.
REQ-013 nhit  output  NCH*CNT_W  per-channel hit counts, registered, packed like data.
REQ-014 ovf  output  NCH  per-channel sticky saturation flag, registered.

Function
REQ-015 Channel k SHALL be "above" when data_k > thresh_k; the compare is unsigned and strict, so equality is not above.
REQ-016 In mode 0, we[k] SHALL equal above_k AND running.
REQ-017 In mode 1, we[k] SHALL equal above_k AND NOT prev_above_k AND running, counting rising crossings only.
REQ-018 prev_above_k SHALL register above_k every cycle, regardless of running or mode.
REQ-019 we SHALL have zero latency from data; nhit SHALL reflect a we one cycle later.
REQ-020 Clear condition: ss=1 AND running=0 SHALL zero all nhit, ovf and prev_above on the next edge.
REQ-021 ss=1 while running=1 SHALL be ignored.
REQ-022 Otherwise, we[k]=1 SHALL increment nhit_k by 1.
REQ-023 nhit_k SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 ovf[k] SHALL set on the first we[k]=1 while nhit_k is already all-ones, and SHALL stay set until the next clear or rst.
REQ-025 A mode change SHALL take effect combinationally on the same cycle; counts already accumulated SHALL be retained.
REQ-026 Channels SHALL be fully independent; simultaneous we on any number of channels SHALL each increment their own counter.
REQ-027 When running=0, all we SHALL be 0 and counters SHALL hold, except when the clear condition applies.

Reset
REQ-028 rst=1 SHALL on the next edge set nhit, ovf, prev_above and the peak register (if present) to 0.
REQ-029 rst SHALL take priority over the clear condition and over any increment.
REQ-030 rst mid-run SHALL discard all counts, and counting SHALL resume on the first edge after rst is deasserted if running=1.
REQ-031 we SHALL remain combinational and is not gated by rst.

Configuration
REQ-032 Macro MULTI_HITCOUNTER_PEAK_EN: when defined, add output peak (NCH*DATA_W) holding, per channel, the maximum data_k sampled while running=1.
REQ-033 peak SHALL be registered, updated when running=1 AND data_k > peak_k, and cleared by rst or the clear condition.
REQ-034 When the macro is undefined, the peak port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 NCH=4, thresh all 100, mode 0; ss pulse with running=0, then running=1 for 10 cycles with ch0 data=150 constant -> nhit0=10, nhit1..3=0, ovf=0.
REQ-036 mode 1; ch1 data alternating 50/200 for 10 running cycles starting at 50 -> nhit1=5; with data held at 200 for 10 cycles -> nhit1=1.
REQ-037 Boundary: data=100 with thresh=100 -> we=0; data=101 -> we=1, one cycle later nhit increments by 1.
REQ-038 CNT_W=4, mode 0, ch2 above for 20 running cycles -> nhit2 stops at 15, ovf[2]=1 from the 16th we; an ss clear with running=0 -> nhit2=0, ovf[2]=0.
REQ-039 rst asserted for 1 cycle mid-run after 5 hits -> nhit=0 next cycle, then counting resumes; ss pulsed while running=1 -> counts unchanged.
REQ-040 With MULTI_HITCOUNTER_PEAK_EN defined, ch3 data sequence 120, 300, 250 while running -> peak3=300; data 500 while running=0 -> peak3 unchanged.
